// File: rtl/e_mdu.sv
// e_mdu: execute-stage multiply/divide unit owning HI/LO, with a busy countdown for MULT/DIV
module e_mdu #(
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);
  localparam int MAXC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CW = $clog2(MAXC + 1);
  localparam logic [CW-1:0] MUL_N1 = CW'(MUL_CYCLES - 1);
  localparam logic [CW-1:0] DIV_N1 = CW'(DIV_CYCLES - 1);
  logic [CW-1:0] cnt;
  logic [63:0] res, mul_s, mul_u;
  logic        wr, acc, is_mul, is_div, bz;
  logic [31:0] bd, abs_a, abs_b, qu, ru, q_s, r_s, q_u, r_u;
  assign acc    = start & ~req & ~busy;
  assign is_mul = (op == 3'd1) || (op == 3'd2);
  assign is_div = (op == 3'd3) || (op == 3'd4);
  assign bz     = (b == 32'd0);
  // divisor forced to 1 on zero so the dividers never see 0; result is discarded anyway
  assign bd     = bz ? 32'd1 : b;
  assign mul_s  = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
  assign mul_u  = {32'd0, a} * {32'd0, b};
  // signed divide via magnitudes keeps 0x80000000 / -1 well defined
  assign abs_a  = a[31] ? -a : a;
  assign abs_b  = bd[31] ? -bd : bd;
  assign qu     = abs_a / abs_b;
  assign ru     = abs_a % abs_b;
  assign q_s    = (a[31] ^ bd[31]) ? -qu : qu;
  assign r_s    = a[31] ? -ru : ru;
  assign q_u    = a / bd;
  assign r_u    = a % bd;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy <= 1'b0;
      hi   <= '0;
      lo   <= '0;
      cnt  <= '0;
      res  <= '0;
      wr   <= 1'b0;
    end else if (busy) begin
      if (cnt == '0) begin
        busy <= 1'b0;
        if (wr) {hi, lo} <= res;
      end else cnt <= cnt - CW'(1);
    end else if (acc) begin
      if (op == 3'd5) hi <= a;
      if (op == 3'd6) lo <= a;
      if (is_mul | is_div) begin
        busy <= 1'b1;
        cnt  <= is_mul ? MUL_N1 : DIV_N1;
        wr   <= is_mul | ~bz;
        res  <= (op == 3'd1) ? mul_s : (op == 3'd2) ? mul_u : (op == 3'd3) ? {r_s, q_s} : {r_u, q_u};
      end
    end
  end
endmodule
